// File: rtl/adpll_err_uart_tx.sv
// Phase-error logger: samples error_i on reference rising edges, buffers the
// samples in a FIFO and streams them as 8N1 UART frames. ERR_UART_ASCII_HEX_EN selects hex-text output.
module adpll_err_uart_tx #(
  parameter int CLKS_PER_BIT = 2240,
  parameter int FIFO_DEPTH   = 16,
  parameter int DECIM        = 1
) (
  input  logic       fpga_clk_i,
  input  logic       reset_ni,
  input  logic       enable_i,
  input  logic       ref_clk_i,
  input  logic [7:0] error_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       overflow_o,
  output logic [7:0] drop_count_o
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          ref_meta, ref_sync, ref_prev, strobe;
  logic [DW-1:0] dec_cnt;
  logic          capture;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_empty, fifo_full, push, pop;
  logic [7:0]    head;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    data;
  logic          pending;

`ifdef ERR_UART_ASCII_HEX_EN
  logic [1:0]    char_idx;
  logic [7:0]    sample;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  assign pending = (char_idx != 2'd0);
`else
  assign pending = 1'b0;
`endif

  // Reference clock is treated as data: two-flop synchronizer, then a registered edge strobe.
  always_ff @(posedge fpga_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ref_meta <= 1'b0;
      ref_sync <= 1'b0;
      ref_prev <= 1'b0;
      strobe   <= 1'b0;
    end else begin
      ref_meta <= ref_clk_i;
      ref_sync <= ref_meta;
      ref_prev <= ref_sync;
      strobe   <= ref_sync & ~ref_prev;
    end
  end

  always_ff @(posedge fpga_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      dec_cnt <= '0;
    end else if (strobe && enable_i) begin
      dec_cnt <= (dec_cnt == DW'(DECIM - 1)) ? '0 : dec_cnt + 1'b1;
    end
  end

  assign capture    = strobe && enable_i && (dec_cnt == '0);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW + 1)'(FIFO_DEPTH));
  assign pop        = (state == IDLE) && !pending && !fifo_empty;
  assign push       = capture && (!fifo_full || pop);
  assign head       = mem[rd_ptr];

  always_ff @(posedge fpga_clk_i) begin
    if (push) mem[wr_ptr] <= error_i;
  end

  always_ff @(posedge fpga_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_o   <= 1'b0;
      drop_count_o <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (capture && fifo_full && !pop) begin
        overflow_o <= 1'b1;
        if (drop_count_o != 8'hFF) drop_count_o <= drop_count_o + 8'd1;
      end
    end
  end

  // Transmitter: tx_o is registered, so a pop in IDLE drives the start bit on the next cycle.
  always_ff @(posedge fpga_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= 3'd0;
      data     <= 8'd0;
      tx_o     <= 1'b1;
      busy_o   <= 1'b0;
`ifdef ERR_UART_ASCII_HEX_EN
      char_idx <= 2'd0;
      sample   <= 8'd0;
`endif
    end else begin
      busy_o <= (state != IDLE) || !fifo_empty || pending;
      case (state)
        IDLE: begin
`ifdef ERR_UART_ASCII_HEX_EN
          if (pending) begin
            data  <= (char_idx == 2'd1) ? hex_char(sample[3:0]) : 8'h0A;
            tx_o  <= 1'b0;
            timer <= TW'(CLKS_PER_BIT - 1);
            state <= START;
          end else if (pop) begin
            sample <= head;
            data   <= hex_char(head[7:4]);
            tx_o   <= 1'b0;
            timer  <= TW'(CLKS_PER_BIT - 1);
            state  <= START;
          end
`else
          if (pop) begin
            data  <= head;
            tx_o  <= 1'b0;
            timer <= TW'(CLKS_PER_BIT - 1);
            state <= START;
          end
`endif
        end
        START: begin
          if (timer == '0) begin
            bit_idx <= 3'd0;
            tx_o    <= data[0];
            timer   <= TW'(CLKS_PER_BIT - 1);
            state   <= DATA;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        DATA: begin
          if (timer == '0) begin
            timer <= TW'(CLKS_PER_BIT - 1);
            if (bit_idx == 3'd7) begin
              tx_o  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_o    <= data[bit_idx + 3'd1];
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        STOP: begin
          if (timer == '0) begin
            state <= IDLE;
`ifdef ERR_UART_ASCII_HEX_EN
            char_idx <= (char_idx == 2'd2) ? 2'd0 : char_idx + 2'd1;
`endif
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adpll_err_uart_tx.sv
// Directed bench for adpll_err_uart_tx: UART frame decoding, timing, decimation,
// overflow and mid-frame reset. Expectations follow ERR_UART_ASCII_HEX_EN when defined.
module tb_adpll_err_uart_tx;

`ifdef ERR_UART_ASCII_HEX_EN
  localparam int FPS = 3;
`else
  localparam int FPS = 1;
`endif

  typedef struct {
    logic [7:0] err;
    logic [7:0] raw;
    logic [7:0] hi;
    logic [7:0] lo;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en0 = 1'b1, ref0 = 1'b0;
  logic [7:0] err0 = 8'd0;
  logic       tx0, busy0, ovf0;
  logic [7:0] drop0;
  logic       en1 = 1'b1, ref1 = 1'b0;
  logic [7:0] err1 = 8'd0;
  logic       tx1, busy1, ovf1;
  logic [7:0] drop1;

  int n_checks = 0;
  int n_pass   = 0;
  int frame_err = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  adpll_err_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .DECIM(1)) dut (
    .fpga_clk_i(clk), .reset_ni(rst_n), .enable_i(en0), .ref_clk_i(ref0),
    .error_i(err0), .tx_o(tx0), .busy_o(busy0), .overflow_o(ovf0), .drop_count_o(drop0)
  );

  adpll_err_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .DECIM(4)) dut_dec (
    .fpga_clk_i(clk), .reset_ni(rst_n), .enable_i(en1), .ref_clk_i(ref1),
    .error_i(err1), .tx_o(tx1), .busy_o(busy1), .overflow_o(ovf1), .drop_count_o(drop1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Decodes 8N1 frames at 4 clocks per bit; frames cut short by reset are discarded.
  task automatic monitor(input int sel);
    logic line;
    logic [7:0] b;
    bit ok, stop_ok;
    forever begin
      @(negedge clk);
      line = sel ? tx1 : tx0;
      if (rst_n && line == 1'b0) begin
        ok = 1; stop_ok = 0; b = 8'd0;
        for (int c = 1; c <= 38; c++) begin
          @(negedge clk);
          line = sel ? tx1 : tx0;
          if (!rst_n) ok = 0;
          if (c >= 6 && c <= 34 && ((c - 6) % 4) == 0) b[(c - 6) / 4] = line;
          if (c == 38) stop_ok = (line == 1'b1);
        end
        if (ok) begin
          if (!stop_ok) frame_err++;
          if (sel != 0) q1.push_back(b);
          else q0.push_back(b);
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic wait_q(input int sel, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((sel != 0 ? q1.size() : q0.size()) >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle0(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy0) break;
      @(negedge clk);
    end
  endtask

  task automatic pulse0();
    @(negedge clk); ref0 = 1'b1;
    repeat (2) @(negedge clk);
    ref0 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [7:0] exp_byte(input logic [7:0] raw, input logic [7:0] hi,
                                          input logic [7:0] lo, input int k);
    if (FPS == 1) return raw;
    if (k == 0) return hi;
    if (k == 1) return lo;
    return 8'h0A;
  endfunction

  initial begin
    vec_t tbl[6];
    vec_t t3[2];
    int bad_tx, bad_flags;
    logic [7:0] fb;
    logic exp_bit;

    tbl[0] = '{err: 8'hA5, raw: 8'hA5, hi: 8'h41, lo: 8'h35};
    tbl[1] = '{err: 8'hFD, raw: 8'hFD, hi: 8'h46, lo: 8'h44};
    tbl[2] = '{err: 8'h00, raw: 8'h00, hi: 8'h30, lo: 8'h30};
    tbl[3] = '{err: 8'hFF, raw: 8'hFF, hi: 8'h46, lo: 8'h46};
    tbl[4] = '{err: 8'h80, raw: 8'h80, hi: 8'h38, lo: 8'h30};
    tbl[5] = '{err: 8'h7F, raw: 8'h7F, hi: 8'h37, lo: 8'h46};
    t3[0]  = '{err: 8'h01, raw: 8'h01, hi: 8'h30, lo: 8'h31};
    t3[1]  = '{err: 8'h05, raw: 8'h05, hi: 8'h30, lo: 8'h35};

    // Reset state, then a long quiet period with no reference edges.
    repeat (5) @(negedge clk);
    check("rst_tx", tx0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_ovf", ovf0, 1'b0);
    check("rst_drop", drop0, 8'd0);
    rst_n = 1'b1;
    bad_tx = 0; bad_flags = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || tx1 !== 1'b1) bad_tx++;
      if (busy0 !== 1'b0 || ovf0 !== 1'b0 || drop0 !== 8'd0 || busy1 !== 1'b0) bad_flags++;
    end
    check("idle_tx_cycles_bad", bad_tx, 0);
    check("idle_flag_cycles_bad", bad_flags, 0);
    $display("idle: 1000 cycles observed");

    // Single-sample frames; vector 0 also checks exact bit timing and busy fall.
    for (int v = 0; v < 6; v++) begin
      q0.delete();
      err0 = tbl[v].err;
      if (v == 0) begin
        fb = exp_byte(tbl[0].raw, tbl[0].hi, tbl[0].lo, 0);
        @(negedge clk); ref0 = 1'b1;
        for (int idx = 1; idx <= 5 + 41 * FPS; idx++) begin
          @(negedge clk);
          if (idx == 2) ref0 = 1'b0;
          if (idx == 4) check("start_not_early", tx0, 1'b1);
          if (idx >= 5 && idx < 45 && ((idx - 5) % 4) == 2) begin
            int j;
            j = (idx - 5) / 4;
            if (j == 0) exp_bit = 1'b0;
            else if (j == 9) exp_bit = 1'b1;
            else exp_bit = fb[j - 1];
            check($sformatf("bit_period_%0d", j), tx0, exp_bit);
          end
          if (idx == 4 + 41 * FPS) check("busy_last_stop", busy0, 1'b1);
          if (idx == 5 + 41 * FPS) check("busy_fall", busy0, 1'b0);
        end
      end else begin
        pulse0();
      end
      wait_q(0, FPS, 100 + 41 * FPS);
      check($sformatf("vec%0d_frames", v), q0.size(), FPS);
      for (int k = 0; k < FPS && k < q0.size(); k++)
        check($sformatf("vec%0d_byte%0d", v, k), q0[k],
              exp_byte(tbl[v].raw, tbl[v].hi, tbl[v].lo, k));
      wait_idle0(100);
      check($sformatf("vec%0d_idle", v), busy0, 1'b0);
      $display("vec %0d: err=%02h frames=%0d", v, tbl[v].err, q0.size());
    end

    // Capture disabled: edges are ignored.
    q0.delete();
    en0 = 1'b0;
    pulse0();
    pulse0();
    repeat (150) @(negedge clk);
    check("disabled_frames", q0.size(), 0);
    check("disabled_busy", busy0, 1'b0);
    en0 = 1'b1;
    $display("enable low: frames=%0d", q0.size());

    // Decimation by 4: eight edges carrying 1..8 yield samples 1 and 5.
    q1.delete();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      err1 = 8'(k);
      ref1 = 1'b1;
      repeat (3) @(negedge clk);
      ref1 = 1'b0;
      repeat (2) @(negedge clk);
    end
    wait_q(1, 2 * FPS, 200 + 82 * FPS);
    repeat (200) @(negedge clk);
    check("decim_frames", q1.size(), 2 * FPS);
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < FPS; k++)
        if (s * FPS + k < q1.size())
          check($sformatf("decim_s%0d_b%0d", s, k), q1[s * FPS + k],
                exp_byte(t3[s].raw, t3[s].hi, t3[s].lo, k));
    check("decim_drop", drop1, 8'd0);
    $display("decim: frames=%0d", q1.size());

    // Overflow: ten captures three cycles apart into a depth-4 FIFO.
    q0.delete();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); ref0 = 1'b1;
      @(negedge clk);
      @(negedge clk); ref0 = 1'b0; err0 = 8'h10 + 8'(k);
    end
    repeat (5) @(negedge clk);
    check("ovf_flag", ovf0, 1'b1);
    check("ovf_drop_count", drop0, 8'd5);
    wait_q(0, 5 * FPS, 200 + 205 * FPS);
    check("ovf_frames", q0.size(), 5 * FPS);
    for (int s = 0; s < 5; s++)
      for (int k = 0; k < FPS; k++)
        if (s * FPS + k < q0.size())
          check($sformatf("ovf_s%0d_b%0d", s, k), q0[s * FPS + k],
                exp_byte(8'h11 + 8'(s), 8'h31, 8'h31 + 8'(s), k));
    wait_idle0(200);
    check("ovf_idle", busy0, 1'b0);
    $display("overflow: frames=%0d drops=%0d", q0.size(), drop0);

    // Reset during data bit 3 with two samples queued.
    err0 = 8'h30;
    @(negedge clk); ref0 = 1'b1;
    for (int idx = 1; idx <= 22; idx++) begin
      @(negedge clk);
      if (idx == 2 || idx == 5 || idx == 8) ref0 = 1'b0;
      if (idx == 3 || idx == 6) ref0 = 1'b1;
      if (idx == 21) begin
        check("mid_bit3_low", tx0, 1'b0);
        check("mid_busy", busy0, 1'b1);
      end
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", tx0, 1'b1);
    check("rst_mid_busy", busy0, 1'b0);
    check("rst_mid_ovf", ovf0, 1'b0);
    check("rst_mid_drop", drop0, 8'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    q0.delete();
    repeat (300) @(negedge clk);
    check("post_rst_frames", q0.size(), 0);
    check("post_rst_busy", busy0, 1'b0);
    check("post_rst_tx", tx0, 1'b1);
    $display("mid-frame reset: frames after release=%0d", q0.size());

    check("stop_bits_bad", frame_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adpll_err_uart_tx.md
Name: adpll_err_uart_tx

Overview:
Hardware counterpart of the simulation error logger. It samples the ADPLL phase error once per reference-clock rising edge, with optional decimation, and buffers the samples in a small FIFO. It then streams them off-chip as 8N1 UART frames so that lock behaviour can be captured on the bench. It sits beside the ADPLL in the 258 MHz fpga_clk_i domain and consumes error_o together with the ref_clk_i reference.

Parameters:
CLKS_PER_BIT, 2240, fpga_clk_i cycles per UART bit (258 MHz / 115200); legal range is at least 2.
FIFO_DEPTH, 16, number of sample entries; must be a power of two and at least 2.
DECIM, 1, capture every DECIM-th reference rising edge; legal range is at least 1.

Ports:
fpga_clk_i  in  1  system clock, the only clock.
reset_ni  in  1  asynchronous active-low reset.
enable_i  in  1  capture enable; draining continues when low.
ref_clk_i  in  1  reference clock, asynchronous to fpga_clk_i, sampled as data.
error_i  in  8  signed phase error from the ADPLL.
tx_o  out  1  UART serial output, idle high.
busy_o  out  1  high while the FIFO is non-empty or the transmitter is not in IDLE.
overflow_o  out  1  sticky flag: at least one sample was dropped.
drop_count_o  out  8  dropped-sample count, saturating at 255.

Behaviour:
- Reset (asynchronous, reset_ni=0):
  - tx_o=1, busy_o=0, overflow_o=0, drop_count_o=0.
  - FIFO emptied, decimation counter=0, FSM=IDLE, synchronizer flops=0.
  - Takes effect immediately, including mid-frame. No partial frame resumes after release.
- Capture:
  - ref_clk_i passes through a 2-flop synchronizer, then a rising-edge detector. Strobe S asserts for 1 cycle in the cycle after the second flop goes high.
  - Decimation counter increments on each strobe while enable_i=1 and wraps at DECIM-1.
  - A capture occurs on a strobe with counter==0. error_i is registered in that same cycle.
  - While enable_i=0: no capture and the counter holds.
- FIFO:
  - Write on capture. Read is issued by the FSM.
  - Write while full with no same-cycle read: the sample is dropped, overflow_o is set, and drop_count_o increments, saturating at 255.
  - Write while full with a same-cycle read: the write is accepted.
  - Read while empty never occurs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop, load the shift register, and go to START.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit index selects the bit.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles, then go to IDLE. A queued entry is popped in the IDLE cycle, so exactly 1 idle-high cycle separates back-to-back frames.
  - Bit timer is a down-counter loaded with CLKS_PER_BIT-1; the state advances when it reaches 0.
- Latency: with the FIFO empty and the FSM idle, a capture in cycle C gives FIFO non-empty at C+1, pop at C+1, and tx_o falling at C+2.
- Frame payload is the raw two's-complement byte of error_i. For example, -3 is sent as 0xFD.
- busy_o is registered. It equals (FSM≠IDLE) or (FIFO non-empty), evaluated on the previous cycle's state.
- enable_i falling mid-frame does not truncate the frame. Buffered samples still drain.

Optional Feature:
Macro ERR_UART_ASCII_HEX_EN.
- Defined:
  - Each sample is sent as 3 frames: upper-nibble ASCII hex ('0'-'9','A'-'F'), lower-nibble ASCII hex, then 0x0A.
  - A 2-bit character index in the FSM selects the frame; the FIFO is popped only before the first character.
  - busy_o stays high across all 3 frames.
- Undefined: a single raw frame per sample, and no character-index logic.

Test Plan:
1. Hold reset_ni=0 then release, with no ref_clk_i edges → tx_o=1, busy_o=0, overflow_o=0, drop_count_o=0 for 1000 cycles.
2. CLKS_PER_BIT=4, error_i=8'hA5, one ref rising edge → 10 bit-periods of 4 cycles: 0,1,0,1,0,0,1,0,1,1. The start bit begins 2 cycles after the capture strobe.
3. DECIM=4, 8 ref edges carrying error_i values 1..8 → exactly 2 frames, with payloads 0x01 and 0x05.
4. CLKS_PER_BIT=4, FIFO_DEPTH=4, 10 captures spaced 3 cycles apart → 5 frames sent (first capture immediately in flight, 4 buffered), overflow_o=1, drop_count_o=5.
5. Assert reset_ni=0 during data bit 3 of a frame, with 2 samples queued → tx_o=1 at once. After release: no frames, busy_o=0.
6. With ERR_UART_ASCII_HEX_EN defined, error_i=8'hA5 → frames 0x41, 0x35, 0x0A in order, and busy_o falls after the third stop bit.
